// File: rtl/duty_cycle_trig_decoder.sv
// Duty-cycle trigger decoder.
// Each period of mod_clk encodes one trigger bit: 25% high is a 1 and 75% high is a 0.
// The decoder times each period and its high time between successive rising edges,
// decides whether the shape is legal, and emits the recovered bit once it is locked.
// A line that has no rising edge for TIMEOUT cycles is reported as stuck.
module duty_cycle_trig_decoder #(
    parameter int CNT_W      = 8,
    parameter int PERIOD_MIN = 3,
    parameter int PERIOD_MAX = 6,
    parameter int TIMEOUT    = 16,
    parameter int LOCK_COUNT = 4,
    parameter int ERRCNT_W   = 8
) (
    input  logic                fastclk,
    input  logic                reset,
    input  logic                mod_clk,
    output logic                trig_out,
    output logic                trig_valid,
    output logic                locked,
    output logic                err,
    output logic [ERRCNT_W-1:0] err_count
);

    localparam int LOCK_W = $clog2(LOCK_COUNT + 1);

    localparam logic [CNT_W-1:0]    CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [ERRCNT_W-1:0] ERR_MAX   = {ERRCNT_W{1'b1}};
    localparam logic [LOCK_W-1:0]   LOCK_LAST = LOCK_W'(LOCK_COUNT - 1);

    typedef enum logic [1:0] {
        IDLE,
        ACQUIRE,
        LOCKED
    } state_t;

    state_t state;

    logic s1;
    logic s2;
    logic s3;
    logic rise;

    logic [CNT_W-1:0]    period_cnt;
    logic [CNT_W-1:0]    hi_cnt;
    logic [LOCK_W-1:0]   lock_cnt;

    logic                period_valid;
    logic                decoded_bit;
    logic                timeout_hit;
    logic [CNT_W:0]      hi_twice;
    logic [CNT_W:0]      period_ext;
    logic [ERRCNT_W-1:0] err_count_inc;

    assign rise = s2 & ~s3;

    // Bring the asynchronous mod_clk into the fastclk domain and keep one delayed copy for edge detection.
    always_ff @(posedge fastclk or posedge reset) begin
        if (reset) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= mod_clk;
            s2 <= s1;
            s3 <= s2;
        end
    end

    // Measure period and high time; a rising edge restarts both at 1 because that cycle is already high.
    always_ff @(posedge fastclk or posedge reset) begin
        if (reset) begin
            period_cnt <= '0;
            hi_cnt     <= '0;
        end else if (rise) begin
            period_cnt <= CNT_W'(1);
            hi_cnt     <= CNT_W'(1);
        end else begin
            if (period_cnt != CNT_MAX) begin
                period_cnt <= period_cnt + 1'b1;
            end
            if (s2 && (hi_cnt != CNT_MAX)) begin
                hi_cnt <= hi_cnt + 1'b1;
            end
        end
    end

    // Judge the period that ends at this rising edge and work out the bit it carries.
    always_comb begin
        hi_twice      = {hi_cnt, 1'b0};
        period_ext    = {1'b0, period_cnt};
        period_valid  = (period_cnt >= CNT_W'(PERIOD_MIN)) &&
                        (period_cnt <= CNT_W'(PERIOD_MAX)) &&
                        (hi_cnt != '0) &&
                        (hi_cnt < period_cnt) &&
                        (hi_twice != period_ext);
        decoded_bit   = (hi_twice < period_ext);
        timeout_hit   = (period_cnt == CNT_W'(TIMEOUT));
        err_count_inc = (err_count == ERR_MAX) ? err_count : err_count + 1'b1;
    end

    // Lock qualification, bit recovery and error reporting, all registered.
    always_ff @(posedge fastclk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            lock_cnt   <= '0;
            trig_out   <= 1'b0;
            trig_valid <= 1'b0;
            locked     <= 1'b0;
            err        <= 1'b0;
            err_count  <= '0;
        end else begin
            trig_valid <= 1'b0;
            err        <= 1'b0;
            case (state)
                IDLE: begin
                    if (rise) begin
                        state    <= ACQUIRE;
                        lock_cnt <= '0;
                    end
                end
                ACQUIRE: begin
                    if (rise) begin
                        if (period_valid) begin
                            trig_out <= decoded_bit;
                            lock_cnt <= lock_cnt + 1'b1;
                            if (lock_cnt == LOCK_LAST) begin
                                state      <= LOCKED;
                                locked     <= 1'b1;
                                trig_valid <= 1'b1;
                            end
                        end else begin
                            err       <= 1'b1;
                            err_count <= err_count_inc;
                            lock_cnt  <= '0;
                        end
                    end else if (timeout_hit) begin
                        err       <= 1'b1;
                        err_count <= err_count_inc;
                        lock_cnt  <= '0;
                        locked    <= 1'b0;
                        state     <= IDLE;
                    end
                end
                LOCKED: begin
                    if (rise) begin
                        if (period_valid) begin
                            trig_out   <= decoded_bit;
                            trig_valid <= 1'b1;
                        end else begin
                            err       <= 1'b1;
                            err_count <= err_count_inc;
                            lock_cnt  <= '0;
                            locked    <= 1'b0;
                            state     <= ACQUIRE;
                        end
                    end else if (timeout_hit) begin
                        err       <= 1'b1;
                        err_count <= err_count_inc;
                        lock_cnt  <= '0;
                        locked    <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state    <= IDLE;
                    lock_cnt <= '0;
                    locked   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_duty_cycle_trig_decoder.sv
// Bench for duty_cycle_trig_decoder.
// Stimulus drives whole mod_clk periods (high part first, so every period starts with a rising edge)
// and queues the event each rising edge should produce; a monitor pops and checks on every trig_valid/err.
module tb_duty_cycle_trig_decoder;

    logic       fastclk;
    logic       reset;
    logic       mod_clk;
    logic       trig_out;
    logic       trig_valid;
    logic       locked;
    logic       err;
    logic [7:0] err_count;

    int compared;
    int mismatched;
    int event_num;

    typedef struct {
        bit is_err;
        bit trig;
        int cnt;
    } exp_t;

    exp_t sb_q[$];

    duty_cycle_trig_decoder #(
        .CNT_W      (8),
        .PERIOD_MIN (3),
        .PERIOD_MAX (6),
        .TIMEOUT    (16),
        .LOCK_COUNT (4),
        .ERRCNT_W   (8)
    ) dut (
        .fastclk    (fastclk),
        .reset      (reset),
        .mod_clk    (mod_clk),
        .trig_out   (trig_out),
        .trig_valid (trig_valid),
        .locked     (locked),
        .err        (err),
        .err_count  (err_count)
    );

    // Free-running 10 ns sampling clock.
    initial begin
        fastclk = 1'b0;
        forever #5 fastclk = ~fastclk;
    end

    // Safety net so the run can never hang.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached (actual running, required finished)");
        $fatal(1, "[TB] watchdog expired");
    end

    // Scoreboard monitor: every output event must match the oldest queued expectation.
    always @(negedge fastclk) begin
        if (!reset && (trig_valid || err)) begin
            exp_t e;
            compared++;
            event_num++;
            if (sb_q.size() == 0) begin
                mismatched++;
                $display("[TB] FAIL event%0d: unexpected event (actual valid=%0b err=%0b trig=%0b cnt=%0d, required none)",
                         event_num, trig_valid, err, trig_out, err_count);
            end else begin
                e = sb_q.pop_front();
                if ((err !== e.is_err) || (trig_valid !== !e.is_err) || (locked !== !e.is_err) ||
                    (int'(err_count) != e.cnt) || (!e.is_err && (trig_out !== e.trig))) begin
                    mismatched++;
                    $display("[TB] FAIL event%0d: actual valid=%0b err=%0b locked=%0b trig=%0b cnt=%0d, required valid=%0b err=%0b locked=%0b trig=%0b cnt=%0d",
                             event_num, trig_valid, err, locked, trig_out, err_count,
                             !e.is_err, e.is_err, !e.is_err, e.trig, e.cnt);
                end
            end
        end
    end

    // Drive one mod_clk period: hi cycles high, then lo cycles low.
    task automatic applyStimulus(input int hi, input int lo);
        mod_clk = 1'b1;
        repeat (hi) @(negedge fastclk);
        mod_clk = 1'b0;
        repeat (lo) @(negedge fastclk);
    endtask

    // Compare a static output against its required value.
    task automatic checkOutput(input string name, input int actual, input int expected);
        compared++;
        if (actual != expected) begin
            mismatched++;
            $display("[TB] FAIL %s: actual %0d, required %0d", name, actual, expected);
        end
    endtask

    task automatic expect_valid(input bit trig, input int cnt);
        exp_t e;
        e.is_err = 1'b0;
        e.trig   = trig;
        e.cnt    = cnt;
        sb_q.push_back(e);
    endtask

    task automatic expect_err(input int cnt);
        exp_t e;
        e.is_err = 1'b1;
        e.trig   = 1'b0;
        e.cnt    = cnt;
        sb_q.push_back(e);
    endtask

    task automatic check_all_zero(input string tag);
        checkOutput({tag, "_trig_out"}, int'(trig_out), 0);
        checkOutput({tag, "_trig_valid"}, int'(trig_valid), 0);
        checkOutput({tag, "_locked"}, int'(locked), 0);
        checkOutput({tag, "_err"}, int'(err), 0);
        checkOutput({tag, "_err_count"}, int'(err_count), 0);
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        event_num  = 0;
        reset      = 1'b1;
        mod_clk    = 1'b0;
        repeat (3) @(negedge fastclk);
        check_all_zero("in_reset");
        reset = 1'b0;
        repeat (3) @(negedge fastclk);
        check_all_zero("after_reset");

        // T1: 75% pattern; rise 1 arms, rises 2..4 acquire, rise 5 locks with bit 0.
        for (int p = 1; p <= 8; p++) begin
            if (p >= 5) expect_valid(1'b0, 0);
            applyStimulus(3, 1);
        end
        checkOutput("t1_locked", int'(locked), 1);
        checkOutput("t1_trig_out", int'(trig_out), 0);
        checkOutput("t1_err_count", int'(err_count), 0);

        // T2: switch to 25%; the first rise still closes a 75% period, later ones carry 1.
        for (int p = 1; p <= 4; p++) begin
            expect_valid((p == 1) ? 1'b0 : 1'b1, 0);
            applyStimulus(1, 3);
        end
        checkOutput("t2_trig_out", int'(trig_out), 1);
        checkOutput("t2_locked", int'(locked), 1);
        checkOutput("t2_err_count", int'(err_count), 0);

        // T3: stuck-low line gives one timeout error, then 75% relocks after 5 rises.
        expect_err(1);
        repeat (20) @(negedge fastclk);
        checkOutput("t3_locked", int'(locked), 0);
        checkOutput("t3_err_count", int'(err_count), 1);
        for (int p = 1; p <= 6; p++) begin
            if (p >= 5) expect_valid(1'b0, 1);
            applyStimulus(3, 1);
        end
        checkOutput("t3_relocked", int'(locked), 1);
        checkOutput("t3_trig_out", int'(trig_out), 0);

        // T4: 50% pattern; first rise closes a good 75% period, every later rise is an error.
        for (int p = 1; p <= 6; p++) begin
            if (p == 1) expect_valid(1'b0, 1);
            else        expect_err(p);
            applyStimulus(2, 2);
        end
        checkOutput("t4_locked", int'(locked), 0);
        checkOutput("t4_err_count", int'(err_count), 6);

        // T5: 8-cycle periods are too long; the error count climbs from 7 and sticks at 255.
        for (int p = 1; p <= 300; p++) begin
            expect_err((6 + p > 255) ? 255 : 6 + p);
            applyStimulus(2, 6);
        end
        checkOutput("t5_err_count", int'(err_count), 255);
        checkOutput("t5_locked", int'(locked), 0);

        // T6: 25% relocks (first rise closes a bad 8-cycle period), then reset mid-lock.
        for (int p = 1; p <= 6; p++) begin
            if (p == 1)      expect_err(255);
            else if (p >= 5) expect_valid(1'b1, 255);
            applyStimulus(1, 3);
        end
        checkOutput("t6_pre_locked", int'(locked), 1);
        checkOutput("t6_pre_trig_out", int'(trig_out), 1);
        #2;
        reset = 1'b1;
        #1;
        check_all_zero("t6_async_reset");
        repeat (2) @(negedge fastclk);
        reset = 1'b0;
        repeat (2) @(negedge fastclk);
        for (int p = 1; p <= 6; p++) begin
            if (p >= 5) expect_valid(1'b1, 0);
            applyStimulus(1, 3);
        end
        checkOutput("t6_locked", int'(locked), 1);
        checkOutput("t6_trig_out", int'(trig_out), 1);
        checkOutput("t6_err_count", int'(err_count), 0);

        repeat (2) @(negedge fastclk);
        checkOutput("pending_events", sb_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
